// File: rtl/trakball_emulator.sv
// Joystick-to-trackball emulator: two wrapping 4-bit counters whose
// step rate ramps from MAX_PERIOD down to MIN_PERIOD ticks while held.
module trakball_emulator #(
  parameter int TICK_DIV    = 12000,
  parameter int MAX_PERIOD  = 16,
  parameter int MIN_PERIOD  = 2,
  parameter int ACCEL_STEPS = 8
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] joy_i,
  output logic [7:0] trakball_o,
  output logic [1:0] dir_o,
  output logic [1:0] moving_o
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(MAX_PERIOD + 1);
  localparam int SW = $clog2(ACCEL_STEPS + 1);

  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PMAX  = PW'(MAX_PERIOD);
  localparam logic [PW-1:0] PMIN  = PW'(MIN_PERIOD);
  localparam logic [SW-1:0] SMAX  = SW'(ACCEL_STEPS);

  typedef enum logic {
    IDLE,
    MOVE
  } st_e;

  logic [TW-1:0] presc_q, presc_d;
  logic          tick;
  logic [1:0]    req, rdir;

  st_e           st_q   [2];
  st_e           st_d   [2];
  logic          dir_q  [2];
  logic          dir_d  [2];
  logic [3:0]    cnt_q  [2];
  logic [3:0]    cnt_d  [2];
  logic [PW-1:0] ph_q   [2];
  logic [PW-1:0] ph_d   [2];
  logic [PW-1:0] per_q  [2];
  logic [PW-1:0] per_d  [2];
  logic [SW-1:0] step_q [2];
  logic [SW-1:0] step_d [2];
  logic [SW-1:0] step_n;

  always_comb begin
    tick    = enable && (presc_q == TLAST);
    presc_d = presc_q;
    if (enable) presc_d = tick ? '0 : presc_q + 1'b1;
    // Index 0 is horizontal (dir 1 = left), 1 is vertical (dir 1 = up)
    req[0]  = joy_i[3] ^ joy_i[2];
    rdir[0] = joy_i[2];
    req[1]  = joy_i[0] ^ joy_i[1];
    rdir[1] = joy_i[0];
    step_n  = '0;
    for (int a = 0; a < 2; a++) begin
      st_d[a]   = st_q[a];
      dir_d[a]  = dir_q[a];
      cnt_d[a]  = cnt_q[a];
      ph_d[a]   = ph_q[a];
      per_d[a]  = per_q[a];
      step_d[a] = step_q[a];
      step_n    = step_q[a] + 1'b1;
      if (enable) begin
        unique case (st_q[a])
          IDLE: begin
            if (req[a]) begin
              st_d[a]   = MOVE;
              dir_d[a]  = rdir[a];
              per_d[a]  = PMAX;
              ph_d[a]   = '0;
              step_d[a] = '0;
            end
          end
          MOVE: begin
            if (!req[a]) begin
              st_d[a]   = IDLE;
              per_d[a]  = PMAX;
              ph_d[a]   = '0;
              step_d[a] = '0;
            end else if (rdir[a] != dir_q[a]) begin
              dir_d[a]  = rdir[a];
              per_d[a]  = PMAX;
              ph_d[a]   = '0;
              step_d[a] = '0;
            end else if (tick) begin
              if (ph_q[a] == per_q[a] - 1'b1) begin
                cnt_d[a] = cnt_q[a] + 1'b1;
                ph_d[a]  = '0;
                if (step_n == SMAX) begin
                  step_d[a] = '0;
                  if (per_q[a] > PMIN) per_d[a] = per_q[a] - 1'b1;
                end else begin
                  step_d[a] = step_n;
                end
              end else begin
                ph_d[a] = ph_q[a] + 1'b1;
              end
            end
          end
          default: st_d[a] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= IDLE;
        dir_q[a]  <= 1'b0;
        cnt_q[a]  <= '0;
        ph_q[a]   <= '0;
        per_q[a]  <= PMAX;
        step_q[a] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= st_d[a];
        dir_q[a]  <= dir_d[a];
        cnt_q[a]  <= cnt_d[a];
        ph_q[a]   <= ph_d[a];
        per_q[a]  <= per_d[a];
        step_q[a] <= step_d[a];
      end
    end
  end

  assign trakball_o = {cnt_q[1], cnt_q[0]};
  assign dir_o      = {dir_q[1], dir_q[0]};
  assign moving_o   = {st_q[1] == MOVE, st_q[0] == MOVE};

endmodule

// File: tb/tb_trakball_emulator.sv
// Directed bench for trakball_emulator with small tick/period settings.
module tb_trakball_emulator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] joy;
  logic [7:0] trak;
  logic [1:0] dir;
  logic [1:0] mov;

  int n_chk = 0;
  int n_err = 0;
  int tb_ph;

  trakball_emulator #(
    .TICK_DIV   (4),
    .MAX_PERIOD (4),
    .MIN_PERIOD (2),
    .ACCEL_STEPS(2)
  ) dut (
    .clk_12mhz (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .joy_i     (joy),
    .trakball_o(trak),
    .dir_o     (dir),
    .moving_o  (mov)
  );

  always #5 clk = ~clk;

  // Prescaler phase as seen by the bench; 3 means next edge is a tick
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ph <= 0;
    else if (enable) tb_ph <= (tb_ph + 1) % 4;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    for (int i = 0; i < 8 && tb_ph != 3; i++) @(negedge clk);
  endtask

  int t[7] = '{4, 8, 11, 14, 16, 18, 20};
  int p;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    joy     = 4'h0;
    cyc(2);
    chk("rst_trak", 32'(trak), 32'h00);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_mov", 32'(mov), 32'h0);
    reset_n = 1'b1;
    cyc(3);

    // Right held from a tick boundary: accelerating steps
    align();
    joy = 4'b1000;
    cyc(1);
    chk("r_entry_mov", 32'(mov), 32'h1);
    p = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(4 * t[i] - 1 - p);
      chk("r_pre", 32'(trak[3:0]), 32'(i));
      cyc(1);
      chk("r_step", 32'(trak[3:0]), 32'(i + 1));
      p = 4 * t[i];
    end
    chk("r_dir", 32'(dir[0]), 32'h0);
    chk("r_mov", 32'(mov[0]), 32'h1);
    chk("r_vcnt", 32'(trak[7:4]), 32'h0);

    // Left and right together cancel
    joy = 4'b1100;
    cyc(2);
    chk("lr_mov", 32'(mov), 32'h0);
    cyc(200);
    chk("lr_cnt", 32'(trak), 32'h07);
    chk("lr_mov2", 32'(mov), 32'h0);

    // Up only
    align();
    joy = 4'b0001;
    cyc(16);
    chk("up_pre", 32'(trak[7:4]), 32'h0);
    cyc(1);
    chk("up_step", 32'(trak[7:4]), 32'h1);
    chk("up_dir", 32'(dir[1]), 32'h1);
    chk("up_mov", 32'(mov), 32'h2);
    chk("up_h", 32'(trak[3:0]), 32'h7);
    joy = 4'h0;
    cyc(2);
    chk("rel_mov", 32'(mov), 32'h0);

    // Reversal once period has reached 2
    align();
    joy = 4'b1000;
    cyc(57);
    chk("rv_pre", 32'(trak[3:0]), 32'd11);
    cyc(1);
    joy = 4'b0100;
    cyc(1);
    chk("rv_dir", 32'(dir[0]), 32'h1);
    chk("rv_mov", 32'(mov[0]), 32'h1);
    cyc(6);
    chk("rv_noold", 32'(trak[3:0]), 32'd11);
    cyc(7);
    chk("rv_pre4", 32'(trak[3:0]), 32'd11);
    cyc(1);
    chk("rv_step4", 32'(trak[3:0]), 32'd12);

    // Asynchronous reset mid-motion
    #2 reset_n = 1'b0;
    #1;
    chk("arst_trak", 32'(trak), 32'h00);
    chk("arst_dir", 32'(dir), 32'h0);
    chk("arst_mov", 32'(mov), 32'h0);
    joy = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("post_rst", {22'h0, trak, dir, mov}, 32'h0);
    end

    // Wrap through 17 steps
    align();
    joy = 4'b1000;
    cyc(144);
    chk("w_14", 32'(trak[3:0]), 32'd14);
    cyc(1);
    chk("w_15", 32'(trak[3:0]), 32'd15);
    cyc(7);
    chk("w_15b", 32'(trak[3:0]), 32'd15);
    cyc(1);
    chk("w_0", 32'(trak[3:0]), 32'd0);
    cyc(8);
    chk("w_1", 32'(trak[3:0]), 32'd1);

    // Freeze at phase 2 of period 4
    joy = 4'h0;
    cyc(2);
    align();
    joy = 4'b1000;
    cyc(10);
    chk("fz_start", 32'(trak), 32'h01);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("fz_hold", 32'(trak), 32'h01);
    end
    chk("fz_mov", 32'(mov), 32'h1);
    enable = 1'b1;
    cyc(6);
    chk("fz_pre", 32'(trak[3:0]), 32'd1);
    cyc(1);
    chk("fz_step", 32'(trak[3:0]), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/trakball_emulator.md
Name: trakball_emulator

Overview:
- Converts digital joystick directions into Centipede/Millipede-style trackball data: two free-running 4-bit wrapping counters (horizontal, vertical), each with a latched direction flag.
- Sits directly upstream of the centipede core's trakball_i input, so keyboard or joypad play works without a real trackball.
- Each axis ramps from slow to fast steps while a direction is held.
- The enable input freezes the block while the CPU is paused.

Parameters:
- TICK_DIV, 12000: clk_12mhz cycles per motion tick (1 kHz at 12 MHz).
- MAX_PERIOD, 16: ticks per step when motion starts (slowest speed).
- MIN_PERIOD, 2: ticks per step at full speed; must be ≥1 and ≤ MAX_PERIOD.
- ACCEL_STEPS, 8: steps taken at one period before the period is decremented by 1.

Ports:
- clk_12mhz  in  1: system clock.
- reset_n  in  1: asynchronous, active-low reset.
- enable  in  1: high = run; low = freeze all state, outputs hold.
- joy_i  in  4: {right, left, down, up}, active-high.
- trakball_o  out  8: {v_count[3:0], h_count[3:0]}.
- dir_o  out  2: {v_dir, h_dir}; h_dir 1 = left, v_dir 1 = up.
- moving_o  out  2: {v_moving, h_moving}; high while the axis is in MOVE.

Behaviour:
- Reset (async assert, sync release): counts 0, dir_o 0, moving_o 0, prescaler 0, both phase counters 0, both periods = MAX_PERIOD, step-in-period counters 0.
- Prescaler:
  - counts 0..TICK_DIV-1 while enable=1.
  - tick pulses for one cycle when it wraps to 0.
  - holds its value while enable=0.
- Axis request, per axis and sampled every cycle (not only on ticks):
  - H: right-only = +, left-only = −, both or neither = none.
  - V: up-only = +, down-only = −, both or neither = none.
- Per-axis FSM, IDLE / MOVE, with transitions evaluated every cycle:
  - IDLE → MOVE when request ≠ none and enable=1. Latch dir (left / up = 1), period = MAX_PERIOD, phase = 0, step counter = 0.
  - MOVE → IDLE when request = none. Period returns to MAX_PERIOD, phase = 0. Count and dir hold their last values.
  - MOVE with reversed request: stay in MOVE, update dir in the same cycle, restart period = MAX_PERIOD, phase = 0, step counter = 0. This is one cycle of reversal only; no IDLE cycle is inserted.
  - In MOVE on each tick:
    - if phase == period−1: step. Count increments modulo 16 in both directions; dir carries the sign. Phase = 0, step counter +1.
    - otherwise phase +1.
  - Acceleration: when the step counter reaches ACCEL_STEPS on a step, period −1 (floored at MIN_PERIOD) and the step counter clears. At MIN_PERIOD the step counter still clears; the period stays.
- First step after entering MOVE occurs on the MAX_PERIOD-th tick after entry.
- If entry or reversal and a tick coincide in one cycle, the entry/reversal wins and the tick is not counted.
- Count wrap: 15 → 0, no flag. The core derives motion from count deltas.
- enable=0 mid-MOVE: FSM state, phase, period and counts freeze. Requests are ignored until enable returns. On return, the current request is re-evaluated per the rules above, so a different request is treated as release or reversal.
- reset_n asserted mid-MOVE: immediate return to the reset state.
- Outputs are registered. A count change is visible the cycle after the tick cycle.
- Axes are fully independent; simultaneous diagonal motion is allowed.

Test Plan:
All scenarios use TICK_DIV=4, MAX_PERIOD=4, MIN_PERIOD=2, ACCEL_STEPS=2, enable=1 unless stated.
- Reset:
  - Stimulus: assert reset_n=0 mid-motion.
  - Required: trakball_o=0x00, dir_o=0, moving_o=0 asynchronously.
  - Stimulus: release reset_n with joy_i=0.
  - Required: outputs stay 0 for 100 cycles.
- Right held from a tick boundary:
  - Required: h_count steps at ticks 4, 8, 11, 14, 16, 18, 20.
  - Required: after the 7th step h_count=7, h_dir=0, h_moving=1, v_count stays 0.
- Left+right held together:
  - Required: h_moving=0, count unchanged for 50 ticks.
- Then up-only held:
  - Required: v_dir=1, v_count increments on tick 4.
- Reversal:
  - Stimulus: right held to period 2, then switch to left.
  - Required: h_dir=1 on the next cycle; next step 4 ticks later (period back to 4).
- Wrap:
  - Stimulus: hold right through 17 steps.
  - Required: h_count goes 15 → 0 → 1.
- Freeze:
  - Stimulus: enable=0 for 40 cycles mid-MOVE with phase=2.
  - Required: trakball_o constant throughout. After enable=1, the next step occurs (period−2) ticks later.
